axi_pwm_custom_capture: RTL and testbench

//  Multi-channel PWM duty-cycle decoder: receive side of the 12-bit PWM LED interface.

---
 rtl/axi_pwm_custom_capture.sv | 202 ++++++++++++++++++++
 tb/tb_axi_pwm_custom_capture.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pwm_custom_capture.sv
`timescale 1ns/1ps
// axi_pwm_custom_capture
// Receive side of the 12-bit PWM LED link: decodes the high time of each of
// NUM_CH asynchronous PWM inputs into a duty code (high cycles per 2**CNT_W
// cycle period) and strobes it towards the AXI capture registers.
// Optional build macro: PWM_CAPTURE_DEGLITCH_EN (3-sample level filter after
// the synchronizer; drops pulses shorter than 3 cycles, adds 2 cycles to both
// edges so measured duty is unchanged).
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no period in flight; waiting for a rise, timing out to static
// S_HIGH | inside the high phase, counting high and period cycles
// S_LOW  | inside the low phase, counting period cycles until next rise
module axi_pwm_custom_capture #(
    parameter int NUM_CH      = 6,
    parameter int CNT_W       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4112
) (
    input  logic                    pwm_clk,
    input  logic                    rstn,
    input  logic [NUM_CH-1:0]       pwm_in,
    output logic [CNT_W*NUM_CH-1:0] duty_out,
    output logic [NUM_CH-1:0]       duty_valid,
    output logic [NUM_CH-1:0]       period_err
);

    localparam int PER_W = CNT_W + 2;
    localparam logic [PER_W-1:0] PERIOD_NOM = PER_W'(2**CNT_W);
    localparam logic [PER_W-1:0] TIMEOUT_C  = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0] PER_MAX    = '1;
    localparam logic [CNT_W-1:0] DUTY_MAX   = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    // Cycles after reset until the edge detector compares two real samples.
    // Before that the cleared pipeline would fake a rise on a pin that is
    // already high, and the first published period would be a partial one.
`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int WARM = SYNC_STAGES + 3;
`else
    localparam int WARM = SYNC_STAGES + 1;
`endif
    localparam int WARM_W = $clog2(WARM + 1);

    logic [WARM_W-1:0] warm_cnt;
    logic              warm_done;

    assign warm_done = (warm_cnt == WARM_W'(WARM));

    // Post-reset warm-up counter shared by all channels.
    always_ff @(posedge pwm_clk) begin
        if (!rstn) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   p;
        logic                   rise;
        logic                   fall;
        logic                   timeout;
        logic [1:0]             state;
        logic [CNT_W-1:0]       hi_cnt;
        logic [CNT_W-1:0]       hi_inc;
        logic [PER_W-1:0]       per_cnt;
        logic [PER_W-1:0]       per_inc;
        logic [CNT_W-1:0]       static_code;
        logic [CNT_W-1:0]       duty_q;
        logic                   valid_q;
        logic                   err_q;

        // Metastability synchronizer for the asynchronous pin.
        always_ff @(posedge pwm_clk) begin
            if (!rstn) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in[ch]};
            end
        end

`ifdef PWM_CAPTURE_DEGLITCH_EN
        logic dg_d1;
        logic dg_d2;
        logic dg_lvl;

        // A new level is taken only once three consecutive samples agree;
        // otherwise the previously accepted level is held.
        assign s = (sync_q[SYNC_STAGES-1] == dg_d1 && dg_d1 == dg_d2) ? dg_d1 : dg_lvl;

        // Sample history and accepted level for the deglitch filter.
        always_ff @(posedge pwm_clk) begin
            if (!rstn) begin
                dg_d1  <= 1'b0;
                dg_d2  <= 1'b0;
                dg_lvl <= 1'b0;
            end else begin
                dg_d1  <= sync_q[SYNC_STAGES-1];
                dg_d2  <= dg_d1;
                dg_lvl <= s;
            end
        end
`else
        assign s = sync_q[SYNC_STAGES-1];
`endif

        assign rise        = s & ~p & warm_done;
        assign fall        = ~s & p;
        assign timeout     = (per_cnt == TIMEOUT_C);
        assign per_inc     = (per_cnt == PER_MAX) ? per_cnt : per_cnt + 1'b1;
        assign hi_inc      = (hi_cnt == DUTY_MAX) ? hi_cnt : hi_cnt + 1'b1;
        assign static_code = s ? DUTY_MAX : '0;

        // Previous-level register for edge detection.
        always_ff @(posedge pwm_clk) begin
            if (!rstn) begin
                p <= 1'b0;
            end else begin
                p <= s;
            end
        end

        // Measurement FSM: counts high and period cycles, publishes on the
        // closing rise or on timeout. A rise beats a coincident timeout.
        always_ff @(posedge pwm_clk) begin
            if (!rstn) begin
                state   <= S_IDLE;
                hi_cnt  <= '0;
                per_cnt <= '0;
                duty_q  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                valid_q <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (rise) begin
                            hi_cnt  <= CNT_W'(1);
                            per_cnt <= PER_W'(1);
                            state   <= S_HIGH;
                        end else if (timeout) begin
                            duty_q  <= static_code;
                            valid_q <= 1'b1;
                            per_cnt <= '0;
                        end else begin
                            per_cnt <= per_inc;
                        end
                    end
                    S_HIGH: begin
                        if (timeout) begin
                            duty_q  <= static_code;
                            valid_q <= 1'b1;
                            per_cnt <= '0;
                            state   <= S_IDLE;
                        end else if (fall) begin
                            per_cnt <= per_inc;
                            state   <= S_LOW;
                        end else begin
                            hi_cnt  <= hi_inc;
                            per_cnt <= per_inc;
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            duty_q  <= hi_cnt;
                            valid_q <= 1'b1;
                            if (per_cnt != PERIOD_NOM) begin
                                err_q <= 1'b1;
                            end
                            hi_cnt  <= CNT_W'(1);
                            per_cnt <= PER_W'(1);
                            state   <= S_HIGH;
                        end else if (timeout) begin
                            duty_q  <= static_code;
                            valid_q <= 1'b1;
                            per_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            per_cnt <= per_inc;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        per_cnt <= '0;
                    end
                endcase
            end
        end

        assign duty_out[CNT_W*ch +: CNT_W] = duty_q;
        assign duty_valid[ch]              = valid_q;
        assign period_err[ch]              = err_q;
    end

endmodule

// File: tb/tb_axi_pwm_custom_capture.sv
`timescale 1ns/1ps
// Directed bench for axi_pwm_custom_capture: per-channel PWM generators with
// hand-picked codes, a monitor recording published duties, one task per scenario.
module tb_axi_pwm_custom_capture;
    localparam int NUM_CH = 6;
    localparam int CNT_W  = 12;

    logic                    pwm_clk = 1'b0;
    logic                    rstn    = 1'b0;
    logic [NUM_CH-1:0]       pwm_in  = '0;
    logic [CNT_W*NUM_CH-1:0] duty_out;
    logic [NUM_CH-1:0]       duty_valid;
    logic [NUM_CH-1:0]       period_err;

    int checks   = 0;
    int failures = 0;

    axi_pwm_custom_capture #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(4112)
    ) dut (
        .pwm_clk    (pwm_clk),
        .rstn       (rstn),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .period_err (period_err)
    );

    always #5 pwm_clk = ~pwm_clk;

    // generator: mode 0 = pwm (per/hi/glitch), 1 = held low, 2 = held high
    int gen_mode   [NUM_CH];
    int gen_per    [NUM_CH];
    int gen_hi     [NUM_CH];
    int gen_phase  [NUM_CH];
    int gen_glitch [NUM_CH];
    bit gen_jitter = 1'b0;

    always @(posedge pwm_clk) begin
        int ofs;
        ofs = gen_jitter ? int'($urandom_range(1, 8)) : 2;
        #(ofs);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (gen_mode[ch])
                0: pwm_in[ch] = (gen_phase[ch] < gen_hi[ch]) && (gen_phase[ch] != gen_glitch[ch]);
                2: pwm_in[ch] = 1'b1;
                default: pwm_in[ch] = 1'b0;
            endcase
            gen_phase[ch] = (gen_phase[ch] + 1 >= gen_per[ch]) ? 0 : gen_phase[ch] + 1;
        end
    end

    // monitor
    int               vcnt      [NUM_CH];
    logic [CNT_W-1:0] last_duty [NUM_CH];
    logic [NUM_CH-1:0] prev_valid = '0;
    int dbl_cnt = 0;
    int min0    = 99999;
    int max0    = -1;

    always @(negedge pwm_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (duty_valid[i] === 1'b1) begin
                vcnt[i]++;
                last_duty[i] = duty_out[CNT_W*i +: CNT_W];
                if (prev_valid[i] === 1'b1) dbl_cnt++;
                if (i == 0) begin
                    if (int'(last_duty[0]) < min0) min0 = int'(last_duty[0]);
                    if (int'(last_duty[0]) > max0) max0 = int'(last_duty[0]);
                end
            end
        end
        prev_valid = duty_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge pwm_clk);
        #1;
    endtask

    task automatic set_pwm(input int ch, input int per, input int hi);
        gen_mode[ch]   = 0;
        gen_per[ch]    = per;
        gen_hi[ch]     = hi;
        gen_glitch[ch] = -1;
        gen_phase[ch]  = 0;
    endtask

    task automatic wait_phase(input int ch, input int ph, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4300 && !ok; i++) begin
            step(1);
            if (gen_phase[ch] == ph) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int ch, output bit ok, output logic [CNT_W-1:0] d);
        int start;
        start = vcnt[ch];
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 4400 && !ok; i++) begin
            step(1);
            if (vcnt[ch] != start) begin
                ok = 1'b1;
                d  = last_duty[ch];
            end
        end
    endtask

    task automatic test_reset();
        set_pwm(0, 4096, 2048);
        set_pwm(1, 4096, 4095);
        set_pwm(2, 4096, 1);
        set_pwm(3, 4000, 1000);
        gen_mode[4] = 1;
        gen_mode[5] = 2;
        rstn = 1'b0;
        step(4);
        checks++;
        if (duty_out !== '0) begin
            failures++; $display("FAIL reset_duty: got %h expected 0", duty_out);
        end
        checks++;
        if (duty_valid !== '0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", duty_valid);
        end
        checks++;
        if (period_err !== '0) begin
            failures++; $display("FAIL reset_err: got %b expected 0", period_err);
        end
        rstn = 1'b1;
    endtask

    task automatic test_nominal();
        int exp_duty [NUM_CH];
        exp_duty = '{2048, 4095, 1, 1000, 0, 4095};
        step(8400);
        for (int i = 0; i < NUM_CH; i++) vcnt[i] = 0;
        step(8192);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vcnt[i] != 2) begin
                failures++; $display("FAIL nominal_rate ch%0d: got %0d pulses expected 2", i, vcnt[i]);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (int'(last_duty[i]) != exp_duty[i]) begin
                failures++;
                $display("FAIL nominal_duty ch%0d: got %0d expected %0d", i, last_duty[i], exp_duty[i]);
            end
        end
        checks++;
        if (period_err !== 6'b001000) begin
            failures++; $display("FAIL nominal_err: got %b expected 001000", period_err);
        end
        checks++;
        if (dbl_cnt != 0) begin
            failures++; $display("FAIL valid_width: got %0d long pulses expected 0", dbl_cnt);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        wait_phase(0, 3000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL midrst_wait: got timeout expected phase 3000");
        end
        gen_hi[0] = 1000;
        for (int i = 1; i < NUM_CH; i++) gen_mode[i] = 1;
        wait_phase(0, 500, ok);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        checks++;
        if (duty_out !== '0) begin
            failures++; $display("FAIL midrst_duty: got %h expected 0", duty_out);
        end
        checks++;
        if (duty_valid !== '0 || period_err !== '0) begin
            failures++; $display("FAIL midrst_flags: got valid=%b err=%b expected 0/0", duty_valid, period_err);
        end
        vcnt[0] = 0;
        step(4096);
        checks++;
        if (vcnt[0] != 0) begin
            failures++; $display("FAIL midrst_partial: got %0d publishes expected 0", vcnt[0]);
        end
        step(4096);
        checks++;
        if (vcnt[0] != 1 || last_duty[0] != 12'd1000) begin
            failures++;
            $display("FAIL midrst_first: got %0d publishes duty %0d expected 1 / 1000", vcnt[0], last_duty[0]);
        end
        checks++;
        if (period_err !== '0) begin
            failures++; $display("FAIL midrst_err: got %b expected 0", period_err);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        int exp_min, exp_max;
        logic exp_err;
`ifdef PWM_CAPTURE_DEGLITCH_EN
        exp_min = 3000; exp_max = 3000; exp_err = 1'b0;
`else
        exp_min = 1499; exp_max = 1500; exp_err = 1'b1;
`endif
        wait_phase(0, 3500, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL glitch_wait: got timeout expected phase 3500");
        end
        gen_hi[0]     = 3000;
        gen_glitch[0] = 1500;
        step(4196);
        min0 = 99999;
        max0 = -1;
        step(8192);
        checks++;
        if (min0 != exp_min || max0 != exp_max) begin
            failures++;
            $display("FAIL glitch_duty: got min %0d max %0d expected %0d / %0d", min0, max0, exp_min, exp_max);
        end
        checks++;
        if (period_err[0] !== exp_err) begin
            failures++; $display("FAIL glitch_err: got %b expected %b", period_err[0], exp_err);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [CNT_W-1:0] d;
        wait_phase(0, 3500, ok);
        gen_hi[0]     = 2048;
        gen_glitch[0] = -1;
        wait_phase(0, 3000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL b2b_wait: got timeout expected phase 3000");
        end
        gen_hi[0] = 100;
        wait_valid(0, ok, d);
        checks++;
        if (!ok || d != 12'd2048) begin
            failures++; $display("FAIL b2b_first: got ok=%0d duty %0d expected 2048", ok, d);
        end
        wait_valid(0, ok, d);
        checks++;
        if (!ok || d != 12'd100) begin
            failures++; $display("FAIL b2b_second: got ok=%0d duty %0d expected 100", ok, d);
        end
        checks++;
        if (duty_valid[0] !== 1'b0 || duty_out[CNT_W-1:0] !== 12'd100) begin
            failures++;
            $display("FAIL b2b_hold: got valid %b duty %0d expected 0 / 100", duty_valid[0], duty_out[CNT_W-1:0]);
        end
    endtask

    task automatic test_async();
        bit ok;
        logic [CNT_W-1:0] d;
        gen_jitter = 1'b1;
        set_pwm(1, 4096, 1234);
        wait_valid(1, ok, d);
        wait_valid(1, ok, d);
        checks++;
        if (!ok || d < 12'd1233 || d > 12'd1235) begin
            failures++; $display("FAIL async_duty: got ok=%0d duty %0d expected 1234 +/-1", ok, d);
        end
        gen_jitter = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            gen_mode[i]   = 1;
            gen_per[i]    = 4096;
            gen_hi[i]     = 0;
            gen_phase[i]  = 0;
            gen_glitch[i] = -1;
            vcnt[i]       = 0;
            last_duty[i]  = 12'd77;
        end
        test_reset();
        test_nominal();
        test_mid_reset();
        test_glitch();
        test_back_to_back();
        test_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
